// File: rtl/muldiv_iter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_iter_pkg                                                  |
// | Operation and state encodings for the iterative HI/LO unit.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package muldiv_iter_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_MUL  = 3'd1,
    OP_MADD = 3'd2,
    OP_MSUB = 3'd3,
    OP_DIV  = 3'd4,
    OP_MTHI = 3'd5,
    OP_MTLO = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_FIX  = 2'd3
  } muldiv_state_t;

  function automatic logic is_mul_op(input muldiv_op_t o);
    return (o == OP_MUL) || (o == OP_MADD) || (o == OP_MSUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter_pp_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mul_pp_step                                                      |
// | Adds MUL_BPC shifted copies of mcand, gated by bits, to acc_in.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mul_pp_step #(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 2
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [MUL_BPC-1:0] bits,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [2*WIDTH-1:0] w_sum;

  always_comb begin
    w_sum = acc_in;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (bits[j]) w_sum = w_sum + (mcand << j);
    end
  end

  assign acc_out = w_sum;

endmodule
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_iter                                                      |
// | Iterative shift-add multiplier / restoring divider owning HI/LO. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic             op_u,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_dw    = 2 * WIDTH;
  localparam int c_cw    = $clog2(WIDTH) + 1;
  localparam int c_mul_k = WIDTH / MUL_BPC;
  localparam logic [c_cw-1:0] c_mul_last = c_cw'(c_mul_k - 1);
  localparam logic [c_cw-1:0] c_div_last = c_cw'(WIDTH - 1);

  if ((WIDTH % MUL_BPC) != 0) begin : g_bpc_check
    $error("muldiv_iter: MUL_BPC must divide WIDTH");
  end

  muldiv_state_t    r_state, w_state_nxt;
  logic [c_cw-1:0]  r_cnt;
  logic [c_dw-1:0]  r_acc, r_mcand;
  logic [WIDTH-1:0] r_mplier;
  muldiv_op_t       r_op;
  logic             r_q_neg, r_r_neg, r_b_zero;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_is_mul, w_is_div, w_accept;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [c_dw-1:0]  w_rem_shift, w_step_acc, w_step_out, w_prod, w_result;
  logic [MUL_BPC-1:0] w_step_bits;
  logic [WIDTH-1:0] w_quot, w_rem;

  assign w_is_mul = is_mul_op(op);
  assign w_is_div = (op == OP_DIV);
  assign w_accept = (r_state == MD_IDLE) && start && !flush;
  assign w_a_neg  = !op_u && a[WIDTH-1];
  assign w_b_neg  = !op_u && b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // Divider reuses the adder: r_mcand holds -divisor, so one gated add is the trial subtract.
  assign w_rem_shift = {r_acc[c_dw-2:0], r_mplier[WIDTH-1]};
  assign w_step_acc  = (r_state == MD_DIV) ? w_rem_shift : r_acc;
  assign w_step_bits = (r_state == MD_DIV) ? MUL_BPC'(1) : r_mplier[MUL_BPC-1:0];

  mul_pp_step #(.WIDTH(WIDTH), .MUL_BPC(MUL_BPC)) u_pp_step (
    .acc_in  (w_step_acc),
    .mcand   (r_mcand),
    .bits    (w_step_bits),
    .acc_out (w_step_out)
  );

  always_comb begin
    w_prod = r_q_neg ? -r_acc : r_acc;
    w_quot = r_b_zero ? '1 : (r_q_neg ? -r_mplier : r_mplier);
    w_rem  = r_r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    case (r_op)
      OP_MADD: w_result = {r_hi, r_lo} + w_prod;
      OP_MSUB: w_result = {r_hi, r_lo} - w_prod;
      OP_DIV:  w_result = {w_rem, w_quot};
      default: w_result = w_prod;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= MD_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (w_accept && w_is_mul) begin
          w_state_nxt = MD_MUL;
          busy        = 1'b1;
        end else if (w_accept && w_is_div) begin
          w_state_nxt = MD_DIV;
          busy        = 1'b1;
        end
      end
      MD_MUL: begin
        busy = 1'b1;
        if (r_cnt == c_mul_last) w_state_nxt = MD_FIX;
      end
      MD_DIV: begin
        busy = 1'b1;
        if (r_cnt == c_div_last) w_state_nxt = MD_FIX;
      end
      MD_FIX: begin
        done        = 1'b1;
        w_state_nxt = MD_IDLE;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = MD_IDLE;
      done        = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_op     <= OP_NOP;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_b_zero <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (start && op == OP_MTHI) r_hi <= a;
          if (start && op == OP_MTLO) r_lo <= a;
          if (start && (w_is_mul || w_is_div)) begin
            r_cnt    <= '0;
            r_op     <= op;
            r_q_neg  <= w_a_neg ^ w_b_neg;
            r_r_neg  <= w_a_neg;
            r_b_zero <= (b == '0);
            r_acc    <= '0;
            r_mcand  <= w_is_div ? -{{WIDTH{1'b0}}, w_b_mag} : {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_is_div ? w_a_mag : w_b_mag;
          end
        end
        MD_MUL: begin
          r_acc    <= w_step_out;
          r_mcand  <= r_mcand << MUL_BPC;
          r_mplier <= r_mplier >> MUL_BPC;
          r_cnt    <= r_cnt + 1'b1;
        end
        MD_DIV: begin
          // Non-negative trial result means the divisor fits: keep it and shift in a 1.
          if (!w_step_out[c_dw-1]) begin
            r_acc    <= w_step_out;
            r_mplier <= {r_mplier[WIDTH-2:0], 1'b1};
          end else begin
            r_acc    <= w_rem_shift;
            r_mplier <= {r_mplier[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
        end
        MD_FIX: {r_hi, r_lo} <= w_result;
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_muldiv_iter                                                   |
// | Directed and reference-model checks for muldiv_iter.             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_muldiv_iter;
  import muldiv_iter_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  muldiv_op_t  op = OP_NOP;
  logic        op_u = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_iter #(.WIDTH(32), .MUL_BPC(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .op_u    (op_u),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge after the result is visible.
  task automatic do_op(input muldiv_op_t o, input logic u, input logic [31:0] x, input logic [31:0] y,
                       input int lat, input logic [31:0] eh, input logic [31:0] el,
                       input string tag, input bit noise);
    int cyc;
    bit busy_ok;
    start = 1'b1; op = o; op_u = u; a = x; b = y;
    #1 chk({tag, " busy@accept"}, 64'(busy), 64'd1);
    @(negedge clock);
    cyc = 1;
    busy_ok = 1'b1;
    if (noise) begin
      op = OP_MTHI;
      a  = 32'hDEADBEEF;
    end else begin
      start = 1'b0;
    end
    #1;
    while (done !== 1'b1 && cyc < 40) begin
      busy_ok &= (busy === 1'b1);
      @(negedge clock);
      #1 cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk({tag, " busy_run"}, 64'(busy_ok), 64'd1);
    chk({tag, " busy@done"}, 64'(busy), 64'd0);
    @(negedge clock);
    start = 1'b0;
    #1;
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
  endtask

  task automatic do_move(input muldiv_op_t o, input logic [31:0] x, input string tag);
    start = 1'b1; op = o; a = x;
    #1 chk({tag, " busy"}, 64'(busy), 64'd0);
    @(negedge clock);
    start = 1'b0;
    #1 chk({tag, " done"}, 64'(done), 64'd0);
  endtask

  function automatic logic [63:0] ref_model(input muldiv_op_t o, input logic u,
                                            input logic [31:0] x, input logic [31:0] y);
    longint sa, sb;
    logic [63:0] ux, uy;
    int sq, sr;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (o != OP_DIV) return u ? ux * uy : 64'(sa * sb);
    if (y == 32'd0) return {x, 32'hFFFFFFFF};
    if (u) return {x % y, x / y};
    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
    sq = $signed(x) / $signed(y);
    sr = $signed(x) % $signed(y);
    return {32'(sr), 32'(sq)};
  endfunction

  initial begin
    bit          done_seen;
    muldiv_op_t  ro;
    logic        ru;
    logic [31:0] rx, ry;
    logic [63:0] rexp;

    repeat (2) @(negedge clock);
    #1;
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    do_op(OP_MUL, 1'b0, 32'hFFFFFFFD, 32'd7, 17, 32'hFFFFFFFF, 32'hFFFFFFEB, "mul_s", 1'b0);
    do_op(OP_DIV, 1'b0, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_s", 1'b0);
    do_op(OP_DIV, 1'b1, 32'd7, 32'd2, 33, 32'd1, 32'd3, "div_u", 1'b0);
    do_op(OP_DIV, 1'b0, 32'h12345678, 32'd0, 33, 32'h12345678, 32'hFFFFFFFF, "div0_s", 1'b0);
    do_op(OP_DIV, 1'b1, 32'h12345678, 32'd0, 33, 32'h12345678, 32'hFFFFFFFF, "div0_u", 1'b0);
    do_op(OP_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000, "div_ovf", 1'b0);
    do_op(OP_DIV, 1'b0, 32'hFFFFFFF9, 32'd0, 33, 32'hFFFFFFF9, 32'hFFFFFFFF, "div0_neg", 1'b0);

    do_move(OP_MTHI, 32'd0, "mthi");
    do_move(OP_MTLO, 32'hFFFFFFFF, "mtlo");
    chk("move hi", 64'(hi), 64'd0);
    chk("move lo", 64'(lo), 64'hFFFFFFFF);
    do_op(OP_MADD, 1'b1, 32'd1, 32'd1, 17, 32'd1, 32'd0, "madd", 1'b0);
    do_op(OP_MSUB, 1'b1, 32'd1, 32'd1, 17, 32'd0, 32'hFFFFFFFF, "msub", 1'b0);

    // Flush a divide at cycle 10.
    start = 1'b1; op = OP_DIV; op_u = 1'b1; a = 32'd100; b = 32'd7;
    @(negedge clock);
    start = 1'b0;
    done_seen = 1'b0;
    for (int c = 1; c < 10; c++) begin
      #1 done_seen |= (done === 1'b1);
      @(negedge clock);
    end
    flush = 1'b1;
    #1 done_seen |= (done === 1'b1);
    @(negedge clock);
    flush = 1'b0;
    #1;
    chk("flush busy@11", 64'(busy), 64'd0);
    chk("flush done", 64'(done_seen | done), 64'd0);
    chk("flush hi", 64'(hi), 64'd0);
    chk("flush lo", 64'(lo), 64'hFFFFFFFF);
    do_op(OP_MUL, 1'b1, 32'd5, 32'd6, 17, 32'd0, 32'd30, "mul_after_flush", 1'b0);

    // Start held high while busy and through the done cycle must be ignored.
    do_op(OP_MUL, 1'b1, 32'd3, 32'd4, 17, 32'd0, 32'd12, "mul_noise", 1'b1);
    do_op(OP_MADD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 17, 32'd0, 32'd13, "madd_s", 1'b0);

    // Flush and start in the same idle cycle: start is dropped.
    start = 1'b1; op = OP_MTLO; a = 32'h55AA55AA; flush = 1'b1;
    #1 chk("flush+start busy", 64'(busy), 64'd0);
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    #1 chk("flush+start lo", 64'(lo), 64'd13);

    // Asynchronous reset in the middle of a multiply.
    start = 1'b1; op = OP_MUL; op_u = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_mid hi", 64'(hi), 64'd0);
    chk("rst_mid lo", 64'(lo), 64'd0);
    chk("rst_mid busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 150; i++) begin
      ro = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
      ru = 1'($urandom_range(0, 1));
      rx = $urandom;
      case ($urandom_range(0, 3))
        0: ry = 32'($urandom_range(0, 9));
        1: ry = -32'($urandom_range(1, 9));
        default: ry = $urandom;
      endcase
      rexp = ref_model(ro, ru, rx, ry);
      do_op(ro, ru, rx, ry, (ro == OP_MUL) ? 17 : 33, rexp[63:32], rexp[31:0], "rand", 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
